// File: rtl/feeder_pkg.sv
// Shared FSM encoding and step-counter width for the systolic-array operand feeder.
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } feeder_state_e;

    // Wide enough for the 2D-1 feed steps of arrays up to D = 128.
    localparam int STEP_W = 8;

endpackage

// File: rtl/feeder_bank.sv
// D x D operand register file with a per-lane anti-diagonal read mux.
// TRANSPOSE=0: lane l = M[l][t-l] (west edge); TRANSPOSE=1: lane l = M[t-l][l] (north edge).
module feeder_bank
    import feeder_pkg::*;
#(
    parameter int N         = 8,
    parameter int D         = 4,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(D)-1:0] wr_row,
    input  logic [$clog2(D)-1:0] wr_col,
    input  logic [N-1:0]         wr_data,
    input  logic [STEP_W-1:0]    step,
    output logic [D*N-1:0]       lanes
);

    logic [N-1:0] mem_q [D][D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < D; r++) begin
                for (int c = 0; c < D; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    // Each lane picks the one element whose index pair sums to the current step.
    always_comb begin
        lanes = '0;
        for (int l = 0; l < D; l++) begin
            for (int k = 0; k < D; k++) begin
                if (int'(step) == l + k) begin
                    if (TRANSPOSE) begin
                        lanes[l*N +: N] = mem_q[k][l];
                    end else begin
                        lanes[l*N +: N] = mem_q[l][k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Skewed A/B operand feeder for a D x D systolic array with clear/feed/drain sequencing.
// Define FEEDER_DBLBUF_EN for ping-pong A/B banks that accept writes while a run is active.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for start; buffers writable
// ST_CLEAR | one-cycle accumulator clear pulse to the array
// ST_FEED  | 2D-1 steps of skewed operands (step counts up)
// ST_DRAIN | D cycles for the wavefront to leave (step counts down)
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(D)-1:0] wr_row,
    input  logic [$clog2(D)-1:0] wr_col,
    input  logic [N-1:0]         wr_data,
    input  logic                 start,
    input  logic                 sn_in,
    output logic [D*N-1:0]       a_edge,
    output logic [D*N-1:0]       b_edge,
    output logic                 sn_out,
    output logic                 pe_clr,
    output logic                 busy,
    output logic                 done
);

    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(2*D-2);
    localparam logic [STEP_W-1:0] DRAIN_INIT = STEP_W'(D-1);

    feeder_state_e     state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              done_q, done_d;
    logic              sn_q;
    logic [D*N-1:0]    a_edge_q, b_edge_q;
    logic [D*N-1:0]    a_rd, b_rd;
    logic              start_acc;

    assign start_acc = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                step_d  = '0;
            end
            ST_FEED: begin
                if (step_q == FEED_LAST) begin
                    state_d = ST_DRAIN;
                    step_d  = DRAIN_INIT;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (step_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            done_q   <= 1'b0;
            sn_q     <= 1'b0;
            a_edge_q <= '0;
            b_edge_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            done_q   <= done_d;
            if (start_acc) sn_q <= sn_in;
            a_edge_q <= (state_q == ST_FEED) ? a_rd : '0;
            b_edge_q <= (state_q == ST_FEED) ? b_rd : '0;
        end
    end

`ifdef FEEDER_DBLBUF_EN
    // bank_q is the bank the array reads; the other one takes all writes.
    logic           bank_q;
    logic [D*N-1:0] a_rd_bk [2];
    logic [D*N-1:0] b_rd_bk [2];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic wr_bank;
        assign wr_bank = wr_en && (bank_q != 1'(g));

        feeder_bank #(.N(N), .D(D), .TRANSPOSE(1'b0)) u_bank_a (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_bank && !wr_sel),
            .wr_row  (wr_row),
            .wr_col  (wr_col),
            .wr_data (wr_data),
            .step    (step_q),
            .lanes   (a_rd_bk[g])
        );

        feeder_bank #(.N(N), .D(D), .TRANSPOSE(1'b1)) u_bank_b (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_bank && wr_sel),
            .wr_row  (wr_row),
            .wr_col  (wr_col),
            .wr_data (wr_data),
            .step    (step_q),
            .lanes   (b_rd_bk[g])
        );
    end

    assign a_rd = a_rd_bk[bank_q];
    assign b_rd = b_rd_bk[bank_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= 1'b0;
        end else if (start_acc) begin
            bank_q <= ~bank_q;
        end
    end
`else
    logic wr_ok;
    assign wr_ok = wr_en && (state_q == ST_IDLE);

    feeder_bank #(.N(N), .D(D), .TRANSPOSE(1'b0)) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .step    (step_q),
        .lanes   (a_rd)
    );

    feeder_bank #(.N(N), .D(D), .TRANSPOSE(1'b1)) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .step    (step_q),
        .lanes   (b_rd)
    );
`endif

    assign a_edge = a_edge_q;
    assign b_edge = b_edge_q;
    assign sn_out = sn_q;
    assign pe_clr = (state_q == ST_CLEAR);
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder (D=2, N=8): directed corner cases plus random runs against a matrix-level model.
module tb_systolic_feeder;

    localparam int N  = 8;
    localparam int D  = 2;
    localparam int IW = $clog2(D);
`ifdef FEEDER_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, wr_en, wr_sel, start, sn_in;
    logic [IW-1:0]  wr_row, wr_col;
    logic [N-1:0]   wr_data;
    logic [D*N-1:0] a_edge, b_edge;
    logic           sn_out, pe_clr, busy, done;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .D(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .start   (start),
        .sn_in   (sn_in),
        .a_edge  (a_edge),
        .b_edge  (b_edge),
        .sn_out  (sn_out),
        .pe_clr  (pe_clr),
        .busy    (busy),
        .done    (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: matrices per bank; act is the bank the current/last run reads.
    logic [N-1:0] ma [2][D][D];
    logic [N-1:0] mb [2][D][D];
    int           act;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) begin
                    ma[b][r][c] = '0;
                    mb[b][r][c] = '0;
                end
        act = 0;
    endtask

    task automatic model_write(input bit sel, input int r, input int c, input logic [N-1:0] v,
                               input bit running);
        int bk;
        if (DBL) bk = 1 - act;
        else if (running) return;
        else bk = 0;
        if (sel) mb[bk][r][c] = v;
        else     ma[bk][r][c] = v;
    endtask

    function automatic logic [D*N-1:0] exp_edge(input bit is_b, input int t, input int bk);
        logic [D*N-1:0] e;
        e = '0;
        if (t < 0 || t > 2*D-2) return e;
        for (int l = 0; l < D; l++) begin
            int idx;
            idx = t - l;
            if (idx >= 0 && idx < D)
                e[l*N +: N] = is_b ? mb[bk][idx][l] : ma[bk][l][idx];
        end
        return e;
    endfunction

    task automatic drive_write(input bit sel, input int r, input int c, input logic [N-1:0] v);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(r);
        wr_col  = IW'(c);
        wr_data = v;
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input logic [N-1:0] v);
        drive_write(sel, r, c, v);
        tick();
        wr_en = 1'b0;
        model_write(sel, r, c, v, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " a_edge"}, 64'(a_edge), 64'd0);
        check({tag, " b_edge"}, 64'(b_edge), 64'd0);
        check({tag, " sn_out"}, 64'(sn_out), 64'd0);
        check({tag, " pe_clr"}, 64'(pe_clr), 64'd0);
        check({tag, " busy"},   64'(busy),   64'd0);
        check({tag, " done"},   64'(done),   64'd0);
    endtask

    // One run from start; optional busy restart (FEED step 1), abort (FEED step 2),
    // write with the start, or write mid-run (FEED step 2).
    task automatic run(input bit sn, input bit bs, input bit ab, input bit ws, input bit mw,
                       input bit w_sel, input int w_r, input int w_c, input logic [N-1:0] w_v);
        int bk, dones;
        bit aborted;
        aborted = 1'b0;
        dones   = 0;
        start = 1'b1;
        sn_in = sn;
        if (ws) drive_write(w_sel, w_r, w_c, w_v);
        tick();
        start = 1'b0;
        sn_in = 1'b0;
        wr_en = 1'b0;
        if (ws) model_write(w_sel, w_r, w_c, w_v, 1'b0);
        if (DBL) act = 1 - act;
        bk = act;
        for (int k = 1; k <= 3*D+1; k++) begin
            check($sformatf("pe_clr k%0d", k), 64'(pe_clr), 64'(k == 1));
            check($sformatf("busy k%0d", k),   64'(busy),   64'(k <= 3*D));
            check($sformatf("done k%0d", k),   64'(done),   64'(k == 3*D+1));
            check($sformatf("sn_out k%0d", k), 64'(sn_out), 64'(sn));
            check($sformatf("a_edge k%0d", k), 64'(a_edge), 64'(exp_edge(1'b0, k-3, bk)));
            check($sformatf("b_edge k%0d", k), 64'(b_edge), 64'(exp_edge(1'b1, k-3, bk)));
            dones += int'(done);
            if (ab && k == 4) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (bs && k == 3) begin
                start = 1'b1;
                sn_in = ~sn;
            end
            if (mw && k == 4) begin
                drive_write(w_sel, w_r, w_c, w_v);
                model_write(w_sel, w_r, w_c, w_v, 1'b1);
            end
            tick();
            start = 1'b0;
            sn_in = 1'b0;
            wr_en = 1'b0;
        end
        if (aborted) begin
            check_all_zero("abort");
            for (int k = 0; k < 3*D+2; k++) begin
                dones += int'(done);
                tick();
            end
            check("abort done_cnt", 64'(dones), 64'd0);
            model_reset();
        end else begin
            check("done_cnt", 64'(dones), 64'd1);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0; sn_in = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Skew case: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        write_elem(0, 0, 0, 8'd1); write_elem(0, 0, 1, 8'd2);
        write_elem(0, 1, 0, 8'd3); write_elem(0, 1, 1, 8'd4);
        write_elem(1, 0, 0, 8'd5); write_elem(1, 0, 1, 8'd6);
        write_elem(1, 1, 0, 8'd7); write_elem(1, 1, 1, 8'd8);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        check("skew A00", 64'(ma[act][0][0]), 64'd1);

        // Signed mode with raw 0xFF operand
        write_elem(0, 0, 0, 8'hFF);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);

        // Start while busy
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);

        // Concurrent write of A[1][1]=9, then the following run
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 8'd9);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);

        // Write in the same cycle as start
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 8'hA5);

        // Reset mid-run, then a run that must read cleared buffers
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 6));
            for (int w = 0; w < nw; w++)
                write_elem(1'($urandom_range(0, 1)), int'($urandom_range(0, D-1)),
                           int'($urandom_range(0, D-1)), N'($urandom));
            run(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, D-1)),
                int'($urandom_range(0, D-1)), N'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits.
REQ-002 SHALL have parameter D, default 4: array dimension; the array has D rows and D columns of PEs.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1: buffer write strobe.
REQ-006 SHALL have port wr_sel, input, 1: write target; 0 = A matrix, 1 = B matrix.
REQ-007 SHALL have port wr_row, input, clog2(D): element row index.
REQ-008 SHALL have port wr_col, input, clog2(D): element column index.
REQ-009 SHALL have port wr_data, input, N: element value.
REQ-010 SHALL have port start, input, 1: single-cycle request to begin a multiply.
REQ-011 SHALL have port sn_in, input, 1: signed-mode select, sampled on an accepted start.
REQ-012 SHALL have port a_edge, output, D*N: west-edge operands; lane i is bits [i*N +: N].
REQ-013 SHALL have port b_edge, output, D*N: north-edge operands; lane j is bits [j*N +: N].
REQ-014 SHALL have port sn_out, output, 1: latched signed mode, held for the whole run.
REQ-015 SHALL have port pe_clr, output, 1: array accumulator-clear pulse.
REQ-016 SHALL have port busy, output, 1: high while a run is in progress.
REQ-017 SHALL have port done, output, 1: single-cycle end-of-run pulse.

Function
REQ-018 SHALL implement a state machine with states IDLE, CLEAR, FEED and DRAIN.
- IDLE -> CLEAR on start.
- CLEAR -> FEED after 1 cycle.
- FEED -> DRAIN after 2D-1 cycles.
- DRAIN -> IDLE after D cycles.
REQ-019 SHALL assert pe_clr only in CLEAR, and SHALL latch sn_out from sn_in on the start cycle.
REQ-020 SHALL, in FEED at step t (0..2D-2), drive a_edge lane i = A[i][t-i] and b_edge lane j = B[t-j][j] when the index is in 0..D-1, and 0 otherwise.
REQ-021 SHALL register a_edge and b_edge: the value for step t appears the cycle after the state/step update, and is 0 in IDLE, CLEAR and DRAIN.
REQ-022 SHALL assert busy in CLEAR, FEED and DRAIN.
REQ-023 SHALL pulse done for exactly 1 cycle on the DRAIN -> IDLE transition, so done arrives 3D+1 cycles after start is accepted.
REQ-024 SHALL ignore start while busy (no restart, no re-latch of sn_out).
REQ-025 SHALL perform a write in IDLE on wr_en, with the value visible to a start in the next cycle.
REQ-026 SHALL, when start and wr_en are both high in IDLE, perform the write before the run, so the run uses the new value.
REQ-027 SHALL treat buffer elements as raw N-bit values, with no sign extension or arithmetic in this block.

Reset
REQ-028 SHALL, on rst (including mid-run): enter IDLE, clear both matrix buffers to 0, and set a_edge = 0, b_edge = 0, sn_out = 0, pe_clr = 0, busy = 0, done = 0.
REQ-029 SHALL not emit a done pulse for a run aborted by rst.

Configuration
REQ-030 SHALL, with FEEDER_DBLBUF_EN defined, provide two A/B banks.
- Writes always go to the shadow bank, including while busy.
- An accepted start swaps banks, and the run reads the former shadow bank.
REQ-031 SHALL, without FEEDER_DBLBUF_EN, provide a single bank and drop writes while busy.

Structure
REQ-032 SHALL take the state enum, state encoding and step-counter width localparam from shared package feeder_pkg.
REQ-033 SHALL implement the D×D register file (write port plus per-lane diagonal read mux) as sub-module feeder_bank, instantiated once per matrix per bank.

Verification
REQ-034 SHALL cover the D=2, N=8 skew case.
- Stimulus: A = [[1,2],[3,4]], B = [[5,6],[7,8]], start.
- Response: a_edge steps (1,0), (2,3), (0,4); b_edge steps (5,0), (7,6), (0,8); done 7 cycles after start.
REQ-035 SHALL cover signed mode.
- Stimulus: sn_in=1 at start, A[0][0] = 8'hFF.
- Response: sn_out = 1 for the whole run; a_edge lane 0 carries 8'hFF unmodified.
REQ-036 SHALL cover start while busy.
- Stimulus: a second start at FEED step 1.
- Response: no effect; exactly one done pulse.
REQ-037 SHALL cover reset mid-run.
- Stimulus: rst during FEED step 2.
- Response: next cycle all outputs are 0, no done pulse, and buffers read 0 on the following run.
REQ-038 SHALL cover concurrent writes.
- Stimulus: write A[1][1] = 9 during a run.
- Response without FEEDER_DBLBUF_EN: the write is dropped.
- Response with FEEDER_DBLBUF_EN: the value 9 appears on the next run only.
